// File: rtl/intr_msg_gen.sv
// Interrupt delivery to the host: INTA# level in legacy mode, or one MSI memory
// write per request assertion, with per-vector mask/pending handling and bounded retry.
module intr_msg_gen #(
    parameter int RETRY_MAX      = 3,
    parameter int BACKOFF_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        intr_request,
    input  logic        msi_enable,
    input  logic        msi_mask,
    input  logic [63:0] msi_addr,
    input  logic [15:0] msi_data,
    input  logic        intx_disable,
    output logic        inta_n_o,
    output logic        msi_pending_o,
    output logic        mst_req_o,
    output logic [63:0] mst_addr_o,
    output logic [31:0] mst_data_o,
    input  logic        mst_ack_i,
    input  logic        mst_done_i,
    input  logic        mst_err_i,
    output logic        msi_fail_o
);

    localparam int RCW = $clog2(RETRY_MAX + 1) < 1 ? 1 : $clog2(RETRY_MAX + 1);
    localparam int BCW = $clog2(BACKOFF_CYCLES + 1) < 1 ? 1 : $clog2(BACKOFF_CYCLES + 1);
    localparam logic [RCW-1:0] RETRY_LIM = RCW'(RETRY_MAX);
    localparam logic [BCW-1:0] BO_LAST   = BCW'(BACKOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DONE = 3'd2,
        BACKOFF   = 3'd3,
        HOLD      = 3'd4
    } state_t;

    // Kept as a plain named signal so checkers can bind to the FSM state.
    state_t         state, state_d;
    logic [RCW-1:0] retry_cnt, retry_cnt_d;
    logic [BCW-1:0] bo_cnt, bo_cnt_d;
    logic           inta_n_d, pend_d, req_d, fail_d;
    logic [63:0]    addr_d;
    logic [31:0]    data_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            retry_cnt     <= '0;
            bo_cnt        <= '0;
            inta_n_o      <= 1'b1;
            msi_pending_o <= 1'b0;
            mst_req_o     <= 1'b0;
            mst_addr_o    <= '0;
            mst_data_o    <= '0;
            msi_fail_o    <= 1'b0;
        end else begin
            state         <= state_d;
            retry_cnt     <= retry_cnt_d;
            bo_cnt        <= bo_cnt_d;
            inta_n_o      <= inta_n_d;
            msi_pending_o <= pend_d;
            mst_req_o     <= req_d;
            mst_addr_o    <= addr_d;
            mst_data_o    <= data_d;
            msi_fail_o    <= fail_d;
        end
    end

    always_comb begin
        state_d     = state;
        retry_cnt_d = retry_cnt;
        bo_cnt_d    = bo_cnt;
        pend_d      = msi_pending_o;
        req_d       = mst_req_o;
        addr_d      = mst_addr_o;
        data_d      = mst_data_o;
        fail_d      = 1'b0;
        // Legacy INTA# is suppressed entirely whenever MSI is enabled.
        inta_n_d    = ~(intr_request & ~intx_disable & ~msi_enable);

        unique case (state)
            IDLE: begin
                if (msi_enable && intr_request) begin
                    if (msi_mask) begin
                        pend_d = 1'b1;
                    end else begin
                        addr_d  = msi_addr;
                        data_d  = {16'h0, msi_data};
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end else begin
                    // Request withdrawn while masked, or MSI disabled: drop pending.
                    pend_d = 1'b0;
                end
            end
            REQ: begin
                // Never withdrawn once issued, regardless of enable/mask changes.
                if (mst_ack_i) begin
                    req_d   = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (mst_done_i) begin
                    if (!mst_err_i) begin
                        pend_d      = 1'b0;
                        retry_cnt_d = '0;
                        state_d     = HOLD;
                    end else if (retry_cnt < RETRY_LIM) begin
                        retry_cnt_d = retry_cnt + 1'b1;
                        bo_cnt_d    = '0;
                        state_d     = BACKOFF;
                    end else begin
                        fail_d      = 1'b1;
                        pend_d      = 1'b0;
                        retry_cnt_d = '0;
                        state_d     = HOLD;
                    end
                end
            end
            BACKOFF: begin
                if (!intr_request || !msi_enable) begin
                    retry_cnt_d = '0;
                    if (!msi_enable) pend_d = 1'b0;
                    state_d     = IDLE;
                end else if (bo_cnt == BO_LAST) begin
                    addr_d  = msi_addr;
                    data_d  = {16'h0, msi_data};
                    req_d   = 1'b1;
                    state_d = REQ;
                end else begin
                    bo_cnt_d = bo_cnt + 1'b1;
                end
            end
            HOLD: begin
                // One message per assertion: wait for the level to drop.
                if (!intr_request || !msi_enable) begin
                    if (!msi_enable) pend_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_intr_msg_gen.sv
// Directed bench for intr_msg_gen: INTx, MSI single-shot, mask/pending, retry,
// mid-flight disable and asynchronous reset during a transaction.
module tb_intr_msg_gen;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        intr_request = 1'b0;
    logic        msi_enable = 1'b0;
    logic        msi_mask = 1'b0;
    logic [63:0] msi_addr = '0;
    logic [15:0] msi_data = '0;
    logic        intx_disable = 1'b0;
    logic        inta_n_o;
    logic        msi_pending_o;
    logic        mst_req_o;
    logic [63:0] mst_addr_o;
    logic [31:0] mst_data_o;
    logic        mst_ack_i = 1'b0;
    logic        mst_done_i = 1'b0;
    logic        mst_err_i = 1'b0;
    logic        msi_fail_o;

    int total = 0;
    int bad   = 0;

    intr_msg_gen #(.RETRY_MAX(3), .BACKOFF_CYCLES(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .intr_request(intr_request),
        .msi_enable(msi_enable), .msi_mask(msi_mask), .msi_addr(msi_addr),
        .msi_data(msi_data), .intx_disable(intx_disable), .inta_n_o(inta_n_o),
        .msi_pending_o(msi_pending_o), .mst_req_o(mst_req_o), .mst_addr_o(mst_addr_o),
        .mst_data_o(mst_data_o), .mst_ack_i(mst_ack_i), .mst_done_i(mst_done_i),
        .mst_err_i(mst_err_i), .msi_fail_o(msi_fail_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bounded wait for mst_req_o; reports how many cycles it took.
    task automatic wait_req(input string tag, input int budget, output int waited);
        waited = 0;
        while (mst_req_o !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        chk(tag, {63'h0, mst_req_o}, 64'h1);
    endtask

    task automatic ack_pulse();
        mst_ack_i = 1'b1;
        tick();
        mst_ack_i = 1'b0;
    endtask

    task automatic done_pulse(input logic err);
        mst_done_i = 1'b1;
        mst_err_i  = err;
        tick();
        mst_done_i = 1'b0;
        mst_err_i  = 1'b0;
    endtask

    // Counts cycles with mst_req_o high over a window.
    task automatic count_req(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (mst_req_o === 1'b1) n++;
        end
    endtask

    initial begin
        int w;
        int n;

        // Reset values
        tick();
        tick();
        chk("rst_inta", {63'h0, inta_n_o}, 64'h1);
        chk("rst_pend", {63'h0, msi_pending_o}, 64'h0);
        chk("rst_req", {63'h0, mst_req_o}, 64'h0);
        chk("rst_addr", mst_addr_o, 64'h0);
        chk("rst_data", {32'h0, mst_data_o}, 64'h0);
        chk("rst_fail", {63'h0, msi_fail_o}, 64'h0);
        rst_i = 1'b0;
        tick();

        // INTx level, one cycle of lag on each edge
        intr_request = 1'b1;
        #1;
        chk("intx_lag_rise", {63'h0, inta_n_o}, 64'h1);
        tick();
        chk("intx_assert", {63'h0, inta_n_o}, 64'h0);
        intr_request = 1'b0;
        #1;
        chk("intx_lag_fall", {63'h0, inta_n_o}, 64'h0);
        tick();
        chk("intx_deassert", {63'h0, inta_n_o}, 64'h1);
        intx_disable = 1'b1;
        intr_request = 1'b1;
        tick();
        tick();
        chk("intx_disabled", {63'h0, inta_n_o}, 64'h1);
        intr_request = 1'b0;
        intx_disable = 1'b0;
        tick();

        // MSI basic: one message per assertion
        msi_enable = 1'b1;
        msi_addr   = 64'h0000_0000_FEE0_0000;
        msi_data   = 16'h4021;
        intr_request = 1'b1;
        tick();
        chk("msi_req_rise", {63'h0, mst_req_o}, 64'h1);
        chk("msi_addr", mst_addr_o, 64'h0000_0000_FEE0_0000);
        chk("msi_data", {32'h0, mst_data_o}, 64'h0000_0000_0000_4021);
        chk("msi_inta_forced", {63'h0, inta_n_o}, 64'h1);
        msi_addr = 64'h1111_2222_3333_4444;
        msi_data = 16'hBEEF;
        tick();
        tick();
        tick();
        chk("msi_req_held", {63'h0, mst_req_o}, 64'h1);
        chk("msi_addr_stable", mst_addr_o, 64'h0000_0000_FEE0_0000);
        ack_pulse();
        chk("msi_req_drop", {63'h0, mst_req_o}, 64'h0);
        tick();
        done_pulse(1'b0);
        count_req(190, n);
        chk("msi_single_shot", n, 64'h0);
        chk("msi_no_fail", {63'h0, msi_fail_o}, 64'h0);
        intr_request = 1'b0;
        tick();
        tick();
        intr_request = 1'b1;
        tick();
        chk("msi_second_req", {63'h0, mst_req_o}, 64'h1);
        chk("msi_second_addr", mst_addr_o, 64'h1111_2222_3333_4444);
        chk("msi_second_data", {32'h0, mst_data_o}, 64'h0000_0000_0000_BEEF);
        ack_pulse();
        done_pulse(1'b0);
        intr_request = 1'b0;
        tick();
        tick();

        // Masked: pending set, message on unmask
        msi_mask = 1'b1;
        intr_request = 1'b1;
        tick();
        chk("mask_pend_set", {63'h0, msi_pending_o}, 64'h1);
        count_req(5, n);
        chk("mask_no_req", n, 64'h0);
        msi_mask = 1'b0;
        tick();
        chk("unmask_req", {63'h0, mst_req_o}, 64'h1);
        chk("unmask_pend_held", {63'h0, msi_pending_o}, 64'h1);
        ack_pulse();
        done_pulse(1'b0);
        chk("unmask_pend_clr", {63'h0, msi_pending_o}, 64'h0);
        intr_request = 1'b0;
        tick();
        tick();
        // Masked then request withdrawn: pending clears, nothing sent
        msi_mask = 1'b1;
        intr_request = 1'b1;
        tick();
        tick();
        chk("mask2_pend_set", {63'h0, msi_pending_o}, 64'h1);
        intr_request = 1'b0;
        tick();
        chk("mask2_pend_clr", {63'h0, msi_pending_o}, 64'h0);
        msi_mask = 1'b0;
        count_req(10, n);
        chk("mask2_no_req", n, 64'h0);

        // Retry: error on every completion, 4 attempts then a fail pulse
        intr_request = 1'b1;
        for (int a = 0; a < 4; a++) begin
            wait_req($sformatf("retry_req%0d", a), (a == 0) ? 5 : 100, w);
            if (a > 0) chk($sformatf("retry_gap%0d", a), {63'h0, (w >= 64)}, 64'h1);
            ack_pulse();
            done_pulse(1'b1);
            chk($sformatf("retry_fail%0d", a), {63'h0, msi_fail_o}, (a == 3) ? 64'h1 : 64'h0);
        end
        tick();
        chk("retry_fail_pulse", {63'h0, msi_fail_o}, 64'h0);
        count_req(100, n);
        chk("retry_hold_no_req", n, 64'h0);
        intr_request = 1'b0;
        tick();
        tick();

        // Mid-flight disable: request held until ack, then INTx takes over
        intr_request = 1'b1;
        tick();
        chk("dis_req", {63'h0, mst_req_o}, 64'h1);
        msi_enable = 1'b0;
        tick();
        tick();
        tick();
        chk("dis_req_held", {63'h0, mst_req_o}, 64'h1);
        ack_pulse();
        chk("dis_req_drop", {63'h0, mst_req_o}, 64'h0);
        done_pulse(1'b0);
        count_req(5, n);
        chk("dis_no_req", n, 64'h0);
        chk("dis_inta_low", {63'h0, inta_n_o}, 64'h0);
        intr_request = 1'b0;
        tick();
        chk("dis_inta_high", {63'h0, inta_n_o}, 64'h1);

        // Asynchronous reset during WAIT_DONE
        msi_enable = 1'b1;
        msi_addr   = 64'hDEAD_0000_FEE0_1000;
        msi_data   = 16'h00A5;
        intr_request = 1'b1;
        tick();
        ack_pulse();
        chk("arst_pre_addr", mst_addr_o, 64'hDEAD_0000_FEE0_1000);
        rst_i = 1'b1;
        #1;
        chk("arst_addr", mst_addr_o, 64'h0);
        chk("arst_data", {32'h0, mst_data_o}, 64'h0);
        chk("arst_req", {63'h0, mst_req_o}, 64'h0);
        chk("arst_inta", {63'h0, inta_n_o}, 64'h1);
        tick();
        rst_i = 1'b0;
        tick();
        chk("arst_fresh_req", {63'h0, mst_req_o}, 64'h1);
        chk("arst_fresh_data", {32'h0, mst_data_o}, 64'h0000_0000_0000_00A5);
        ack_pulse();

        // Request falls on the same cycle as the completion: HOLD exits next cycle
        intr_request = 1'b0;
        done_pulse(1'b0);
        tick();
        intr_request = 1'b1;
        tick();
        chk("sim_fall_new_req", {63'h0, mst_req_o}, 64'h1);
        ack_pulse();
        done_pulse(1'b0);
        intr_request = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intr_msg_gen.md
Name: intr_msg_gen

Overview:
Consumes the level interrupt request from the e1000 interrupt controller and delivers it to the host over PCI. In legacy mode it drives INTA# as a level. In MSI mode it converts each assertion of the request into exactly one MSI memory-write, issued through a request/ack/done handshake to the PCI master engine. It also handles the MSI per-vector mask/pending bits and bounded retry on master abort or error.

Parameters:
RETRY_MAX, 3, number of re-issues after an error completion before giving up on that assertion
BACKOFF_CYCLES, 64, idle clk_i cycles between an error completion and the retry

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
intr_request  in  1  level interrupt request from the interrupt controller
msi_enable  in  1  MSI Enable bit from config space (0 = INTx mode)
msi_mask  in  1  MSI per-vector mask bit
msi_addr  in  64  MSI message address
msi_data  in  16  MSI message data
intx_disable  in  1  Command register Interrupt Disable bit
inta_n_o  out  1  legacy INTA#, active-low
msi_pending_o  out  1  MSI pending bit for config readback
mst_req_o  out  1  write request to PCI master
mst_addr_o  out  64  write address
mst_data_o  out  32  write data; {16'h0, msi_data}
mst_ack_i  in  1  master accepted request
mst_done_i  in  1  one-cycle completion pulse
mst_err_i  in  1  qualifies mst_done_i; 1 = abort/error
msi_fail_o  out  1  one-cycle pulse when RETRY_MAX is exhausted

Behaviour:
- Reset values: inta_n_o=1, msi_pending_o=0, mst_req_o=0, mst_addr_o=0, mst_data_o=0, msi_fail_o=0. FSM=IDLE, retry counter=0.
- INTx path, used when msi_enable=0:
  - inta_n_o is registered as ~(intr_request & ~intx_disable), so it changes 1 cycle after the input.
  - When msi_enable=1, inta_n_o is forced to 1.
- MSI FSM states: IDLE, REQ, WAIT_DONE, BACKOFF, HOLD.
- IDLE:
  - If msi_enable & intr_request & ~msi_mask: latch msi_addr and msi_data into mst_addr_o/mst_data_o, assert mst_req_o, go to REQ. mst_req_o rises 1 cycle after the condition.
  - If msi_enable & intr_request & msi_mask: set msi_pending_o and stay in IDLE.
- REQ:
  - Hold mst_req_o and the address/data stable until mst_ack_i.
  - On the cycle mst_ack_i is seen, deassert mst_req_o next cycle and go to WAIT_DONE.
  - An in-flight request is never withdrawn, even if msi_enable or msi_mask changes.
- WAIT_DONE, on mst_done_i:
  - If ~mst_err_i: clear msi_pending_o and retry counter, go to HOLD.
  - If mst_err_i and retry counter < RETRY_MAX: increment counter, go to BACKOFF.
  - Otherwise: pulse msi_fail_o, clear counter and msi_pending_o, go to HOLD.
- BACKOFF:
  - Count BACKOFF_CYCLES, then re-latch msi_addr/msi_data and go to REQ.
  - If intr_request falls or msi_enable clears during BACKOFF, abandon the retry: clear counter, go to IDLE.
- HOLD:
  - Wait for intr_request=0 or msi_enable=0, then go to IDLE.
  - This guarantees one message per request assertion (edge semantics over a level source).
- Pending/mask handling:
  - msi_pending_o is set while masked with the request asserted.
  - On unmask in IDLE with msi_pending_o=1 and intr_request still 1: send the message.
  - If intr_request dropped while masked: clear msi_pending_o without sending.
- msi_enable cleared in IDLE/HOLD/BACKOFF: go to IDLE and clear pending. In REQ/WAIT_DONE, finish the transaction, then go to IDLE.
- Simultaneous intr_request fall and mst_done_i: apply the completion rules; HOLD exits on the next cycle.
- mst_ack_i or mst_done_i arriving outside the expected state is ignored.
- Asynchronous reset mid-transaction returns everything to reset values immediately; the master must be reset in the same domain.

Test Plan:
- INTx: msi_enable=0, intr_request 0→1→0 → inta_n_o 1→0→1, each edge lagging by 1 cycle. With intx_disable=1, inta_n_o stays 1.
- MSI basic: msi_enable=1, msi_addr=64'h0000_0000_FEE0_0000, msi_data=16'h4021, intr_request held high 200 cycles, ack after 3 cycles, done with err=0 → exactly one request with addr FEE00000 and data 32'h0000_4021, then no further request until intr_request drops and rises again.
- Masked: msi_mask=1, raise intr_request → msi_pending_o=1, no mst_req_o. Clear mask → one message, then msi_pending_o=0. Repeat, but drop the request before unmasking → pending clears and no message is sent.
- Retry: err=1 on every completion with RETRY_MAX=3 → 4 requests total, each ≥64 idle cycles after the previous done, then a single msi_fail_o pulse and the FSM in HOLD.
- Mid-flight disable: clear msi_enable while in REQ → mst_req_o held until ack, transaction completes, FSM returns to IDLE, inta_n_o behaves per INTx rule afterwards.
- Reset asserted during WAIT_DONE → all outputs at reset values the same cycle. After release, an asserted intr_request produces a fresh message.
